multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Decodes the 6-bit opcode and sequences fetch/decode/execute/memory/writeback, one state per cycle, stalling on memory handshake.
- Produces the 2-bit ALUOp consumed by the ALU control decoder, plus all datapath enables.
- Keeps cycle and retired-instruction counters for the performance lab.

Parameters:
- CNT_W, 32, width of cycle_cnt_o and instr_cnt_o; counters wrap modulo 2^CNT_W.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- opcode_i  input  6  instruction register [31:26], valid from DECODE onward
- mem_ready_i  input  1  memory access completes this cycle
- ALUOp_o  output  2  00 R-type (decode funct), 01 add, 10 sub (beq), 11 sub (bne)
- alu_src_a_o  output  1  0 PC, 1 rs
- alu_src_b_o  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_write_o  output  1  unconditional PC write
- branch_o  output  1  PC write if ALU zero
- branch_ne_o  output  1  PC write if ALU not zero
- pc_source_o  output  2  00 ALU result, 01 ALUOut, 10 jump target
- iord_o  output  1  0 PC addresses memory, 1 ALUOut
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- ir_write_o  output  1  load instruction register
- reg_dst_o  output  1  0 rt, 1 rd
- mem_to_reg_o  output  1  0 ALUOut, 1 MDR
- reg_write_o  output  1  register file write
- illegal_o  output  1  unrecognised opcode seen
- state_o  output  4  current state code
- cycle_cnt_o  output  CNT_W  cycles since reset
- instr_cnt_o  output  CNT_W  instructions retired

Behaviour:
- Registers reset asynchronously when rst_i is low: state=FETCH(0), counters=0, illegal_o=0.
- All other outputs are Moore decodes of state. In FETCH they are driven as listed below; illegal_o is 0.
- States and codes:
  - FETCH(0): mem_read, ir_write, alu_src_a=0, alu_src_b=01, ALUOp=01, pc_source=00. pc_write and ir_write are asserted only while mem_ready_i=1. Stay in FETCH until mem_ready_i=1, then go to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, ALUOp=01 (branch target into ALUOut). Next state by opcode:
    - 000000 -> EXEC_R
    - 100011, 101011 -> MEM_ADDR
    - 001000 -> EXEC_I
    - 000100, 000101 -> BRANCH
    - 000010 -> JUMP
    - other -> ILLEGAL
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, ALUOp=01. Go to MEM_RD if lw, MEM_WR if sw.
  - MEM_RD(3): mem_read, iord=1. Wait for mem_ready_i, then go to MEM_WB.
  - MEM_WB(4): reg_write, reg_dst=0, mem_to_reg=1. Retires; go to FETCH.
  - MEM_WR(5): mem_write, iord=1. Wait for mem_ready_i; retires on the ready cycle; go to FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, ALUOp=00. Go to R_WB.
  - R_WB(7): reg_write, reg_dst=1, mem_to_reg=0. Retires; go to FETCH.
  - EXEC_I(8): alu_src_a=1, alu_src_b=10, ALUOp=01. Go to I_WB.
  - I_WB(9): reg_write, reg_dst=0, mem_to_reg=0. Retires; go to FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, pc_source=01. beq gives ALUOp=10, branch=1; bne gives ALUOp=11, branch_ne=1. Retires; go to FETCH.
  - JUMP(11): pc_write, pc_source=10. Retires; go to FETCH.
  - ILLEGAL(12): sets illegal_o. Behaviour depends on the optional feature.
- Unused state codes 13-15 go to FETCH; all enables are 0 in those states.
- Signals not listed for a state are 0.
- Latency in cycles, with zero memory wait: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3. Each memory wait cycle adds 1.
- cycle_cnt_o increments every cycle after reset.
- instr_cnt_o increments on the cycle leaving a retiring state, i.e. the MEM_WR ready cycle or a MEM_WB/R_WB/I_WB/BRANCH/JUMP cycle.
- illegal_o is sticky until reset.
- rst_i asserted mid-instruction: immediate return to FETCH; outputs take reset values the same cycle; counters clear.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is terminal. The FSM holds there with all enables 0 and the counters frozen until reset.
- Undefined: ILLEGAL acts as a 1-cycle NOP, retires (instr_cnt increments) and goes to FETCH. illegal_o stays set.

Test Plan:
- Reset low, then high, opcode=000000, mem_ready_i=1 -> states 0,1,6,7,0. ALUOp 01,01,00,xx. reg_write and reg_dst=1 in R_WB. instr_cnt=1 after 4 cycles.
- lw (100011) with mem_ready_i low for 2 cycles in MEM_RD -> 7 cycles total. mem_read and iord=1 held 3 cycles. mem_to_reg=1 in MEM_WB.
- beq (000100) then bne (000101) -> BRANCH with ALUOp=10/branch=1, then ALUOp=11/branch_ne=1. Each instruction is 3 cycles.
- FETCH with mem_ready_i=0 for 3 cycles -> pc_write and ir_write stay 0; state_o=0; cycle_cnt increments to 3.
- opcode=111111 -> illegal_o=1. Trap build: state_o stays 12 and counters freeze. Non-trap build: back to FETCH next cycle, instr_cnt increments.
- rst_i pulsed low during MEM_WR -> state_o=0, mem_write_o=0 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath, with cycle and retired-instruction counters.
// Optional ILLEGAL_TRAP_EN: an illegal opcode parks the FSM in ILLEGAL with counters frozen until reset.
module multi_cycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic [1:0]       ALUOp_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             branch_ne_o,
    output logic [1:0]       pc_source_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic             retire_c;
    logic             freeze_c;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cyc_q     <= '0;
            ins_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
        end
    end

    // Next-state and Moore output decode; only FETCH gates its writes on mem_ready_i.
    always_comb begin
        state_d      = S_FETCH;
        retire_c     = 1'b0;
        freeze_c     = 1'b0;
        ALUOp_o      = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        branch_ne_o  = 1'b0;
        pc_source_o  = 2'b00;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                alu_src_b_o = 2'b01;
                ALUOp_o     = 2'b01;
                state_d     = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                ALUOp_o     = 2'b01;
                case (opcode_i)
                    OP_R:           state_d = S_EXEC_R;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ALUOp_o     = 2'b01;
                state_d     = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                state_d    = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                retire_c     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                retire_c    = mem_ready_i;
                state_d     = mem_ready_i ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                retire_c    = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ALUOp_o     = 2'b01;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
                retire_c    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                pc_source_o = 2'b01;
                ALUOp_o     = opcode_i[0] ? 2'b11 : 2'b10;
                branch_ne_o = opcode_i[0];
                branch_o    = ~opcode_i[0];
                retire_c    = 1'b1;
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
                retire_c    = 1'b1;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                freeze_c = 1'b1;
                state_d  = S_ILLEGAL;
`else
                retire_c = 1'b1;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Sticky flag is set on entry so it is already visible during the ILLEGAL cycle.
    always_comb begin
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
        cyc_d     = freeze_c ? cyc_q : cyc_q + CNT_W'(1);
        ins_d     = retire_c ? ins_q + CNT_W'(1) : ins_q;
    end

    assign illegal_o   = illegal_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cyc_q;
    assign instr_cnt_o = ins_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, scoreboard-based bench for multi_cycle_ctrl; honours ILLEGAL_TRAP_EN when defined.
module tb_multi_cycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  opcode_i;
    logic        mem_ready_i;
    logic [1:0]  ALUOp_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic        pc_write_o, branch_o, branch_ne_o;
    logic [1:0]  pc_source_o;
    logic        iord_o, mem_read_o, mem_write_o, ir_write_o;
    logic        reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt_o, instr_cnt_o;

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .ALUOp_o(ALUOp_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .pc_write_o(pc_write_o), .branch_o(branch_o), .branch_ne_o(branch_ne_o),
        .pc_source_o(pc_source_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .illegal_o(illegal_o),
        .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  st;
        logic [1:0]  aluop;
        logic [14:0] ctrl;
        logic        ill;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] m_cyc = 0, m_ins = 0;
    logic        m_ill = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [14:0] act_ctrl;
    assign act_ctrl = {alu_src_a_o, alu_src_b_o, pc_write_o, branch_o, branch_ne_o,
                       pc_source_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                       reg_dst_o, mem_to_reg_o, reg_write_o};

    // Expected enables from the state table: {src_a, src_b, pc_wr, br, br_ne, pc_src, iord, mrd, mwr, irw, rdst, m2r, rw}
    function automatic logic [14:0] ref_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        case (st)
            4'd0:  return {1'b0, 2'b01, rdy, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, rdy, 3'b000};
            4'd1:  return {1'b0, 2'b11, 12'b0};
            4'd2:  return {1'b1, 2'b10, 12'b0};
            4'd3:  return {3'b000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000};
            4'd4:  return {3'b000, 5'b00000, 4'b0000, 3'b011};
            4'd5:  return {3'b000, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
            4'd6:  return {1'b1, 2'b00, 12'b0};
            4'd7:  return {3'b000, 5'b00000, 4'b0000, 3'b101};
            4'd8:  return {1'b1, 2'b10, 12'b0};
            4'd9:  return {3'b000, 5'b00000, 4'b0000, 3'b001};
            4'd10: return {1'b1, 2'b00, 1'b0, (op == 6'b000100), (op == 6'b000101), 2'b01, 7'b0};
            4'd11: return {3'b000, 1'b1, 2'b00, 2'b10, 7'b0};
            default: return 15'b0;
        endcase
    endfunction

    function automatic logic [1:0] ref_aluop(input logic [3:0] st, input logic [5:0] op);
        case (st)
            4'd0, 4'd1, 4'd2, 4'd8: return 2'b01;
            4'd10:                  return (op == 6'b000100) ? 2'b10 : 2'b11;
            default:                return 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, push expectation, compare popped entry, then advance the model.
    task automatic step(input logic rdy, input logic [3:0] st);
        exp_t e;
        mem_ready_i = rdy;
        if (st == 4'd12) m_ill = 1'b1;
        sb.push_back('{st: st, aluop: ref_aluop(st, opcode_i), ctrl: ref_ctrl(st, rdy, opcode_i),
                       ill: m_ill, cyc: m_cyc, ins: m_ins});
        #1;
        e = sb.pop_front();
        chk($sformatf("state@%0d", m_cyc), 32'(state_o), 32'(e.st));
        chk($sformatf("aluop@%0d", m_cyc), 32'(ALUOp_o), 32'(e.aluop));
        chk($sformatf("ctrl@%0d", m_cyc), 32'(act_ctrl), 32'(e.ctrl));
        chk($sformatf("illegal@%0d", m_cyc), 32'(illegal_o), 32'(e.ill));
        chk($sformatf("cycle_cnt@%0d", m_cyc), cycle_cnt_o, e.cyc);
        chk($sformatf("instr_cnt@%0d", m_cyc), instr_cnt_o, e.ins);
        @(posedge clk_i);
        if (!(TRAP && st == 4'd12)) begin
            m_cyc++;
            if (st == 4'd4 || st == 4'd7 || st == 4'd9 || st == 4'd10 || st == 4'd11 ||
                (st == 4'd5 && rdy) || (st == 4'd12 && !TRAP))
                m_ins++;
        end
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_ins = 0;
        m_ill = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        opcode_i = 6'b000000;
        mem_ready_i = 1'b0;
        #2;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_cyc", cycle_cnt_o, 32'd0);
        chk("reset_ins", instr_cnt_o, 32'd0);
        chk("reset_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // FETCH stall, then R-type
        step(0, 0); step(0, 0); step(0, 0);
        opcode_i = 6'b000000; step(1, 0); step(1, 1); step(1, 6); step(1, 7);
        opcode_i = 6'b001000; step(1, 0); step(1, 1); step(1, 8); step(1, 9);
        // lw with two wait cycles in MEM_RD
        opcode_i = 6'b100011; step(1, 0); step(1, 1); step(1, 2); step(0, 3); step(0, 3); step(1, 3); step(1, 4);
        opcode_i = 6'b101011; step(1, 0); step(1, 1); step(1, 2); step(1, 5);
        opcode_i = 6'b000100; step(1, 0); step(1, 1); step(1, 10);
        opcode_i = 6'b000101; step(1, 0); step(1, 1); step(1, 10);
        opcode_i = 6'b000010; step(1, 0); step(1, 1); step(1, 11);

        // sw stalled in MEM_WR, then asynchronous reset between clock edges
        opcode_i = 6'b101011; step(1, 0); step(1, 1); step(1, 2); step(0, 5);
        mem_ready_i = 1'b0;
        #2;
        chk("pre_rst_memwrite", 32'(mem_write_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_memwrite", 32'(mem_write_o), 32'd0);
        chk("async_rst_cyc", cycle_cnt_o, 32'd0);
        chk("async_rst_ins", instr_cnt_o, 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Illegal opcode
        opcode_i = 6'b111111; step(1, 0); step(1, 1);
`ifdef ILLEGAL_TRAP_EN
        step(1, 12); step(1, 12); step(1, 12);
`else
        step(1, 12);
        opcode_i = 6'b000000; step(1, 0); step(1, 1); step(1, 6); step(1, 7); step(0, 0);
`endif
        rst_i = 1'b0;
        #1;
        model_reset();
        chk("final_rst_illegal", 32'(illegal_o), 32'd0);
        chk("final_rst_state", 32'(state_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
